// File: rtl/pipe_scroller_if.sv
// Control/status bundle between game logic and the pipe scroller.
// master: drives start/gameOver, reads board/move/pipe_passed/state.
interface pipe_scroller_if #(
    parameter int ROWS = 15,
    parameter int COLS = 16
);
    logic                 start;
    logic                 gameOver;
    logic [ROWS*COLS-1:0] board;
    logic                 move;
    logic                 pipe_passed;
    logic [1:0]           state;

    modport master (
        output start, gameOver,
        input  board, move, pipe_passed, state
    );

    modport slave (
        input  start, gameOver,
        output board, move, pipe_passed, state
    );
endinterface

// File: rtl/pipe_scroller.sv
// Scrolling pipe field: shifts the board left on each tick, injects
// pipes with LFSR gap rows, speeds up, and runs an idle/run/frozen FSM.
// Ports: clk, reset (async, active low), bus (slave):
//   start/gameOver in; board, move, pipe_passed, state out.
module pipe_scroller #(
    parameter int         ROWS          = 15,
    parameter int         COLS          = 16,
    parameter int         GAP           = 4,
    parameter int         SPACING       = 4,
    parameter int         PERIOD_INIT   = 175,
    parameter int         PERIOD_MIN    = 40,
    parameter int         SPEED_STEP    = 5,
    parameter int         SPEEDUP_EVERY = 8,
    parameter logic [7:0] SEED          = 8'hA5
) (
    input  logic           clk,
    input  logic           reset,
    pipe_scroller_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FROZEN = 2'd2;

    localparam int W    = ROWS * COLS;
    localparam int PW   = $clog2(PERIOD_INIT + 2);
    localparam int SW   = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam int PCW  = $clog2(SPEEDUP_EVERY + 2);
    localparam int NPOS = ROWS - GAP + 1;

    localparam logic [ROWS-1:0] GMASK =
        ROWS'((64'd1 << GAP) - 64'd1);

    logic [1:0]      state_q;
    logic [W-1:0]    board_q;
    logic            move_q;
    logic            pass_q;
    logic [PW-1:0]   timer;
    logic [PW-1:0]   period;
    logic [SW-1:0]   spacing_cnt;
    logic [PCW-1:0]  pipe_cnt;
    logic [7:0]      lfsr;

    logic [7:0]      lfsr_nxt;
    logic [ROWS-1:0] pipe_col;
    logic [ROWS-1:0] new_col;
    logic [PW-1:0]   period_dn;
    logic            inject;
    logic            last_pipe;
    logic            go_run;
    int              gpos;

    assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    assign inject    = (spacing_cnt == '0);
    assign last_pipe = (SPEEDUP_EVERY != 0) &&
                       (pipe_cnt == PCW'(SPEEDUP_EVERY - 1));
    assign go_run    = bus.start && !bus.gameOver;

    always_comb begin
        gpos     = int'(lfsr) % NPOS;
        pipe_col = ~(GMASK << gpos);
        new_col  = inject ? pipe_col : '0;
    end

    // Saturate at the floor instead of wrapping below it.
    always_comb begin
        if (int'(period) >= PERIOD_MIN + SPEED_STEP)
            period_dn = period - PW'(SPEED_STEP);
        else
            period_dn = PW'(PERIOD_MIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            board_q     <= '0;
            move_q      <= 1'b0;
            pass_q      <= 1'b0;
            timer       <= '0;
            period      <= PW'(PERIOD_INIT);
            spacing_cnt <= '0;
            pipe_cnt    <= '0;
            lfsr        <= SEED;
        end else begin
            lfsr   <= lfsr_nxt;
            move_q <= 1'b0;
            pass_q <= 1'b0;
            unique case (state_q)
                IDLE, FROZEN: begin
                    if (state_q == IDLE)
                        board_q <= '0;
                    if (go_run) begin
                        state_q     <= RUN;
                        board_q     <= '0;
                        timer       <= '0;
                        spacing_cnt <= '0;
                        pipe_cnt    <= '0;
                        period      <= PW'(PERIOD_INIT);
                    end
                end
                RUN: begin
                    // gameOver wins over a due shift.
                    if (bus.gameOver) begin
                        state_q <= FROZEN;
                    end else if (timer == period) begin
                        timer   <= '0;
                        board_q <= {new_col, board_q[W-1:ROWS]};
                        move_q  <= 1'b1;
                        pass_q  <= |board_q[ROWS-1:0];
                        if (inject) begin
                            spacing_cnt <= SW'(SPACING - 1);
                            if (last_pipe) begin
                                pipe_cnt <= '0;
                                period   <= period_dn;
                            end else begin
                                pipe_cnt <= pipe_cnt + PCW'(1);
                            end
                        end else begin
                            spacing_cnt <= spacing_cnt - SW'(1);
                        end
                    end else begin
                        timer <= timer + PW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.board       = board_q;
    assign bus.move        = move_q;
    assign bus.pipe_passed = pass_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_pipe_scroller.sv
// Scoreboard bench for pipe_scroller: random games planned by a
// reference model, checked by an independent negedge monitor.
module tb_pipe_scroller;
    localparam int         ROWS    = 15;
    localparam int         COLS    = 4;
    localparam int         GAP     = 4;
    localparam int         SPACING = 2;
    localparam int         PINIT   = 8;
    localparam int         PMIN    = 4;
    localparam int         STEP    = 2;
    localparam int         EVERY   = 2;
    localparam logic [7:0] SEED    = 8'hA5;
    localparam int         W       = ROWS * COLS;
    localparam int         NG      = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_scroller_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    pipe_scroller #(
        .ROWS(ROWS), .COLS(COLS), .GAP(GAP), .SPACING(SPACING),
        .PERIOD_INIT(PINIT), .PERIOD_MIN(PMIN), .SPEED_STEP(STEP),
        .SPEEDUP_EVERY(EVERY), .SEED(SEED)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int           cyc;
        bit           mv;
        logic [W-1:0] brd;
        bit           pp;
        logic [1:0]   st;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Clock edges since reset release; lfsr has stepped cyc times.
    always @(posedge clk or negedge reset)
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;

    function automatic logic [7:0] lfsr_at(int n);
        logic [7:0] v = SEED;
        for (int i = 0; i < n; i++)
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    function automatic logic [ROWS-1:0] gap_col(int g);
        logic [ROWS-1:0] c = '1;
        for (int r = g; r < g + GAP; r++) c[r] = 1'b0;
        return c;
    endfunction

    function automatic int period_for(int pipes);
        int p = PINIT - STEP * (pipes / EVERY);
        return (p < PMIN) ? PMIN : p;
    endfunction

    task automatic push(input int c, input bit mv, input logic [W-1:0] b,
                        input bit pp, input logic [1:0] st);
        exp_t e;
        e.cyc = c; e.mv = mv; e.brd = b; e.pp = pp; e.st = st;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   hit;
        if (!reset) begin
            chk("rst_state", W'(bus.state), '0);
            chk("rst_board", bus.board, '0);
            chk("rst_pulse", W'({bus.move, bus.pipe_passed}), '0);
        end else begin
            hit = 1'b0;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed cyc=%0d actual=absent required=entry@%0d",
                         cyc, sb[0].cyc);
                sb.delete(0);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e   = sb.pop_front();
                hit = 1'b1;
                chk("move", W'(bus.move), W'(e.mv));
                chk("pipe_passed", W'(bus.pipe_passed), W'(e.pp));
                chk("state", W'(bus.state), W'(e.st));
                chk("board", bus.board, e.brd);
            end
            if (!hit)
                chk("stray_pulse", W'({bus.move, bus.pipe_passed}), '0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int              e0, t, pipes, n, d, iv, gcyc, f, g, wn;
        logic [ROWS-1:0] cols [COLS];
        logic [ROWS-1:0] nc;
        logic [W-1:0]    bflat;
        bit              pass;

        bus.start    = 1'b0;
        bus.gameOver = 1'b0;
        repeat (3) @(negedge clk);
        for (int c = 1; c <= 50; c++) push(c, 1'b0, '0, 1'b0, 2'd0);
        #2 reset = 1'b1;
        // Idle, with start only when gameOver also holds it back.
        for (int i = 0; i < 49; i++) begin
            @(negedge clk);
            bus.gameOver = 1'($urandom % 2);
            bus.start    = bus.gameOver & 1'($urandom % 2);
        end
        @(negedge clk);

        for (int gm = 0; gm < NG; gm++) begin
            bus.start    = 1'b1;
            bus.gameOver = 1'b0;
            e0 = cyc + 1;
            push(e0, 1'b0, '0, 1'b0, 2'd1);
            foreach (cols[i]) cols[i] = '0;
            bflat = '0;
            pipes = 0;
            t     = e0;
            n     = $urandom_range(2, 14);
            for (int k = 1; k <= n; k++) begin
                t   += period_for(pipes) + 1;
                pass = (cols[0] != '0);
                if ((k - 1) % SPACING == 0) begin
                    g  = int'(lfsr_at(t - 1)) % (ROWS - GAP + 1);
                    nc = gap_col(g);
                    pipes++;
                end else begin
                    nc = '0;
                end
                for (int i = 0; i < COLS - 1; i++) cols[i] = cols[i + 1];
                cols[COLS - 1] = nc;
                for (int i = 0; i < COLS; i++)
                    bflat[i * ROWS +: ROWS] = cols[i];
                push(t, 1'b1, bflat, pass, 2'd1);
            end
            iv   = period_for(pipes) + 1;
            d    = ($urandom % 2 == 0) ? iv : $urandom_range(1, iv);
            gcyc = t + d;
            f    = $urandom_range(5, 30);

            if (gm == NG - 1) begin
                wn = $urandom_range(1, gcyc - 2 - e0);
                repeat (wn) begin
                    @(negedge clk);
                    bus.start = 1'($urandom % 2);
                end
                #3 reset = 1'b0;
                sb.delete();
                bus.start    = 1'b0;
                bus.gameOver = 1'b0;
                repeat (3) @(negedge clk);
                for (int c = 1; c <= 50; c++)
                    push(c, 1'b0, '0, 1'b0, 2'd0);
                #2 reset = 1'b1;
                repeat (52) @(negedge clk);
            end else begin
                for (int c = gcyc; c < gcyc + f; c++)
                    push(c, 1'b0, bflat, 1'b0, 2'd2);
                @(negedge clk);
                while (cyc < gcyc - 1) begin
                    bus.start = 1'($urandom % 2);
                    @(negedge clk);
                end
                bus.gameOver = 1'b1;
                bus.start    = 1'($urandom % 2);
                while (cyc < gcyc + f - 1) begin
                    @(negedge clk);
                    bus.start = 1'($urandom % 2);
                end
            end
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover actual=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_scroller.md
# pipe_scroller

Parametrised scrolling pipe field for the Flappy Bird LED board: owns all `COLS` columns of `ROWS` pixels, shifts them one column left on every scroll tick, and injects new pipe columns on the right with pseudo-random gap positions. It adds a game-state FSM (idle / run / frozen), pipe spacing, a pass-count pulse for scoring, and a scroll rate that speeds up as the game progresses. It sits between the game-control logic (`start`, `gameOver`) and the LED driver / collision logic that consume `board`.

## Interface
- `ROWS`, 15: pixels per column.
- `COLS`, 16: columns on the board.
- `GAP`, 4: gap height in rows. Requires 1 ≤ `GAP` < `ROWS`.
- `SPACING`, 4: columns from one pipe to the next. Requires ≥ 1.
- `PERIOD_INIT`, 175: initial tick period. Cycles between shifts = period + 1.
- `PERIOD_MIN`, 40: floor for the period. Requires ≤ `PERIOD_INIT`.
- `SPEED_STEP`, 5: amount subtracted from the period at each speed-up.
- `SPEEDUP_EVERY`, 8: pipes injected per speed-up. 0 disables speed-up.
- `SEED`, 8'hA5: LFSR reset value. Must be nonzero.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: level; sampled each clock.
- `gameOver`  in  1: level; freezes scrolling.
- `board`  out  `ROWS*COLS`: column c is `board[c*ROWS +: ROWS]`. Column 0 is leftmost; bit r = 1 means row r is lit.
- `move`  out  1: one-cycle pulse in the first cycle `board` shows shifted content.
- `pipe_passed`  out  1: one-cycle pulse, coincident with `move`, when the column shifted out of column 0 was nonzero.
- `state`  out  2: 0 = IDLE, 1 = RUN, 2 = FROZEN.

## Operation
- Reset (`reset` = 0, asynchronous) sets:
  - `state` = IDLE, `board` = 0, `move` = 0, `pipe_passed` = 0.
  - timer = 0, period = `PERIOD_INIT`, spacing_cnt = 0, pipe_cnt = 0, lfsr = `SEED`.
- LFSR:
  - 8-bit Fibonacci, taps x^8 + x^6 + x^5 + x^4 + 1.
  - Shifts left every clock in every state while out of reset.
  - Never resets on `start`.
- IDLE:
  - `board` is held at 0.
  - `start` = 1 and `gameOver` = 0 → RUN.
- RUN:
  - Timer increments each clock. When timer == period: timer ← 0 and a shift occurs on that edge.
  - Shift: column c ← column c+1 for c < `COLS`-1; column `COLS`-1 ← new column.
  - New column when spacing_cnt == 0: all ones except rows g..g+`GAP`-1, which are 0.
    - g = lfsr mod (`ROWS`-`GAP`+1), using the current lfsr value.
    - spacing_cnt ← `SPACING`-1; pipe_cnt increments.
  - Otherwise the new column is all zeros and spacing_cnt decrements.
  - Speed-up: when an injection makes pipe_cnt reach `SPEEDUP_EVERY`:
    - pipe_cnt ← 0.
    - period ← max(period − `SPEED_STEP`, `PERIOD_MIN`), with no underflow.
    - The new period applies from the next timer count.
  - `gameOver` = 1 → FROZEN. `start` is ignored while in RUN.
- FROZEN:
  - `board`, timer, period and counters are held.
  - `start` = 1 and `gameOver` = 0 → RUN.
- Entering RUN from either IDLE or FROZEN (same edge as the state change):
  - `board` ← 0, timer ← 0, spacing_cnt ← 0, pipe_cnt ← 0, period ← `PERIOD_INIT`.
  - The first shift therefore injects a pipe.

## Timing
- Start edge E0 enters RUN. The first shift happens at edge E0 + period + 1, and subsequent shifts every period + 1 cycles.
- `move` and `pipe_passed` are registered. They are high for the single cycle after the shift edge, and never high outside RUN.
- A pipe appears in column `COLS`-1 on the first shift and reaches column 0 after `COLS`-1 further shifts.
- `pipe_passed` fires on the following shift, i.e. the `COLS`+1-th shift counting from injection.
- `gameOver` = 1 in the same cycle as timer == period: no shift, no pulse, go to FROZEN. `gameOver` has priority.
- `start` and `gameOver` both high: no transition out of IDLE or FROZEN.
- Reset asserted mid-shift: all state clears immediately, with no partial shift.
- Outputs change only on `clk` edges or on asynchronous reset.

## Test plan
All scenarios use `ROWS`=15, `COLS`=4, `GAP`=4, `SPACING`=2, `PERIOD_INIT`=8, `PERIOD_MIN`=4, `SPEED_STEP`=2, `SPEEDUP_EVERY`=2.

- **Reset / idle:** assert `reset`=0 mid-run, then release and hold `start`=0 for 50 cycles → `board`=0, `state`=0, `move`=0 throughout.
- **First shift:** pulse `start` → first `move` 9 cycles after the start edge.
  - Column 3 = ~(4'hF << g) & 15'h7FFF, with g = lfsr mod 12, checked against an LFSR model.
  - Columns 0–2 = 0.
- **Pipe travel and spacing:**
  - Move 2 injects a zero column.
  - Move 3 injects a pipe.
  - The first pipe is in column 0 after move 4.
  - `pipe_passed` = 1 with move 5, and only then.
- **Speed-up:**
  - Move intervals are 9,9,9 cycles, then 7 after the second pipe is injected (move 3).
  - After the fourth pipe the interval is 5, and it stays 5 thereafter (`PERIOD_MIN` floor).
- **Freeze:**
  - `gameOver` asserted exactly in the timer == period cycle → no `move`, `board` unchanged for 30 cycles, `state`=2.
  - `start` with `gameOver`=1 → stays 2.
- **Restart:** in FROZEN, `gameOver`=0 and `start`=1 → next cycle `board`=0 and `state`=1. The next move occurs 9 cycles after the restart edge (period restored to 8).
